// File: rtl/uart_tx_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_queue                                                |
// | Description : Circular byte FIFO that feeds a UART transmitter through the |
// |               four-phase Send/Sent handshake.                              |
// |               Optional build macro UART_TXQ_STICKY_OVERFLOW_EN makes the   |
// |               overflow flag sticky and adds the ovf_clear input.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_queue #(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
`ifdef UART_TXQ_STICKY_OVERFLOW_EN
    input  logic              ovf_clear,
`endif
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_send,
    output logic [7:0]        tx_din,
    input  logic              tx_sent,
    output logic              busy
);

    localparam logic [1:0]      c_idle     = 2'd0;
    localparam logic [1:0]      c_send     = 2'd1;
    localparam logic [1:0]      c_wait_low = 2'd2;
    localparam logic [ADDR_W:0] c_depth    = (ADDR_W+1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [1:0]        r_state;
    logic              r_tx_send;
    logic              r_busy;
    logic              r_overflow;
    logic [7:0]        r_tx_din;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // A stale Sent level left over from the transmitter holds off the next pop.
    assign w_pop  = (r_state == c_idle) && !w_empty && !tx_sent;
    assign w_push = wr_en && (!w_full || w_pop);
    assign w_drop = wr_en && w_full && !w_pop;

    // Storage carries no reset; validity is defined solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_din   <= 8'h00;
            r_overflow <= 1'b0;
            r_tx_send  <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= c_idle;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end

            // When full, a simultaneous write lands in the slot being popped; the
            // non-blocking read still returns the oldest byte.
            if (w_pop) begin
                r_tx_din <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase

`ifdef UART_TXQ_STICKY_OVERFLOW_EN
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clear) begin
                r_overflow <= 1'b0;
            end
`else
            r_overflow <= w_drop;
`endif

            case (r_state)
                c_idle: begin
                    if (w_pop) begin
                        r_state   <= c_send;
                        r_tx_send <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                c_send: begin
                    if (tx_sent) begin
                        r_state   <= c_wait_low;
                        r_tx_send <= 1'b0;
                    end
                end
                c_wait_low: begin
                    if (!tx_sent) begin
                        r_state <= c_idle;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= c_idle;
                    r_tx_send <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign tx_send  = r_tx_send;
    assign tx_din   = r_tx_din;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_queue                                             |
// | Description : Directed bench for uart_tx_queue with a queue-based model    |
// |               and a simple transmitter responder.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_queue;

    localparam int DEPTH = 16;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_sent = 1'b0;
`ifdef UART_TXQ_STICKY_OVERFLOW_EN
    logic       ovf_clear = 1'b0;
`endif
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_send;
    logic [7:0] tx_din;
    logic       busy;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
`ifdef UART_TXQ_STICKY_OVERFLOW_EN
        .ovf_clear(ovf_clear),
`endif
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_send  (tx_send),
        .tx_din   (tx_din),
        .tx_sent  (tx_sent),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: a byte queue plus the handshake phase (0 idle, 1 sending, 2 waiting for Sent low).
    logic [7:0] m_q[$];
    int         m_phase = 0;
    logic [7:0] m_din   = 8'h00;
    bit         m_ovf   = 1'b0;
    bit         m_pop;
    bit         m_drop;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_phase = 0;
            m_din   = 8'h00;
            m_ovf   = 1'b0;
        end else begin
            m_pop  = (m_phase == 0) && (m_q.size() > 0) && !tx_sent;
            m_drop = wr_en && (m_q.size() == DEPTH) && !m_pop;
`ifdef UART_TXQ_STICKY_OVERFLOW_EN
            if (m_drop) m_ovf = 1'b1;
            else if (ovf_clear) m_ovf = 1'b0;
`else
            m_ovf = m_drop;
`endif
            if (m_pop) m_din = m_q.pop_front();
            if (wr_en && !m_drop) m_q.push_back(wr_data);
            if (m_pop) m_phase = 1;
            else if (m_phase == 1 && tx_sent) m_phase = 2;
            else if (m_phase == 2 && !tx_sent) m_phase = 0;
        end
    end

    bit chk_en     = 1'b0;
    bit track_peak = 1'b0;
    int peak       = 0;
    int ovf_cycles = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic       e_empty;
            logic       e_full;
            logic       e_send;
            logic       e_busy;
            e_empty = (m_q.size() == 0);
            e_full  = (m_q.size() == DEPTH);
            e_send  = (m_phase == 1);
            e_busy  = (m_phase != 0);
            n_vec++;
            if (count !== 5'(m_q.size()) || empty !== e_empty || full !== e_full ||
                overflow !== m_ovf || tx_send !== e_send || busy !== e_busy || tx_din !== m_din) begin
                n_err++;
                $display("FAIL model_cmp t=%0t count got %0d want %0d, empty got %b want %b, full got %b want %b, ovf got %b want %b, send got %b want %b, busy got %b want %b, din got %h want %h",
                         $time, count, m_q.size(), empty, e_empty, full, e_full, overflow, m_ovf,
                         tx_send, e_send, busy, e_busy, tx_din, m_din);
            end
            if (track_peak && int'(count) > peak) peak = int'(count);
            if (overflow) ovf_cycles++;
        end
    end

    // Transmitter responder: raises Sent sent_delay cycles into a transfer, drops it once Send falls.
    int         sent_delay = 4;
    bit         stuck_low  = 1'b0;
    bit         force_high = 1'b0;
    int         hi_cnt     = 0;
    bit         prev_send  = 1'b0;
    logic [7:0] sent_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (tx_send && !prev_send) sent_log.push_back(tx_din);
            prev_send = tx_send;
            if (force_high) begin
                tx_sent = 1'b1;
            end else if (tx_send) begin
                hi_cnt++;
                tx_sent = !stuck_low && (hi_cnt >= sent_delay);
            end else begin
                hi_cnt  = 0;
                tx_sent = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while ((busy || !empty) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, int'(busy || !empty), 0);
    endtask

    initial begin
        int k;
        int base;

        // Reset and idle
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_empty", int'(empty), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_tx_send", int'(tx_send), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tx_din", int'(tx_din), 8'h00);

        // Single byte, slow transmitter
        sent_delay = 100;
        wr_en = 1'b1;
        wr_data = 8'h41;
        @(negedge clk);
        wr_en = 1'b0;
        chk("lat1_tx_send", int'(tx_send), 0);
        @(negedge clk);
        chk("lat2_tx_send", int'(tx_send), 1);
        chk("lat2_tx_din", int'(tx_din), 8'h41);
        drain("single_drain", 300);
        chk("single_sent_n", sent_log.size(), 1);
        chk("single_byte", int'(sent_log[0]), 8'h41);

        // Five back-to-back bytes
        sent_delay = 4;
        peak = 0;
        track_peak = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h10 + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        drain("burst_drain", 500);
        track_peak = 1'b0;
        chk("burst_peak", peak, 4);
        chk("burst_sent_n", sent_log.size(), 6);
        for (int i = 0; i < 5; i++) chk("burst_order", int'(sent_log[1+i]), 8'h10 + i);

        // Fill past DEPTH with Sent stuck low
        stuck_low = 1'b1;
        base = sent_log.size();
        ovf_cycles = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            if (i == DEPTH + 1) begin
                chk("fill_full", int'(full), 1);
                chk("fill_count", int'(count), DEPTH);
            end
            wr_en = 1'b1;
            wr_data = 8'h20 + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
`ifdef UART_TXQ_STICKY_OVERFLOW_EN
        chk("fill_ovf_sticky", int'(overflow), 1);
`else
        chk("fill_ovf_pulses", ovf_cycles, 2);
`endif
        chk("fill_count_hold", int'(count), DEPTH);
        chk("fill_tx_send", int'(tx_send), 1);

        // Write while full in the pop cycle
        stuck_low = 1'b0;
        k = 0;
        while (!(m_phase == 0 && m_q.size() == DEPTH) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("popwr_reach_idle", int'(busy), 0);
        wr_en = 1'b1;
        wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        chk("popwr_count", int'(count), DEPTH);
        chk("popwr_tx_send", int'(tx_send), 1);
`ifdef UART_TXQ_STICKY_OVERFLOW_EN
        chk("popwr_ovf", int'(overflow), 1);
`else
        chk("popwr_ovf", int'(overflow), 0);
`endif
        drain("popwr_drain", 3000);
        chk("popwr_sent_n", sent_log.size() - base, DEPTH + 2);
        for (int i = 0; i < DEPTH + 1; i++) chk("popwr_order", int'(sent_log[base+i]), 8'h20 + i);
        chk("popwr_last", int'(sent_log[base+DEPTH+1]), 8'hA5);

        // Reset while sending with three bytes queued
        sent_delay = 20;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h50 + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        k = 0;
        while (!(tx_send && count == 5'd3) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reach", int'(count), 3);
        force_high = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_tx_send", int'(tx_send), 0);
        chk("mid_count", int'(count), 0);
        chk("mid_empty", int'(empty), 1);
        wr_en = 1'b1;
        wr_data = 8'h77;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("stale_tx_send", int'(tx_send), 0);
        chk("stale_count", int'(count), 1);
        force_high = 1'b0;
        k = 0;
        while (!tx_send && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("stale_release_send", int'(tx_send), 1);
        chk("stale_release_din", int'(tx_din), 8'h77);
        drain("final_drain", 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
